// File: rtl/flag_unit_pkg.sv
// Shared definitions for the status-flag unit: flag bit positions, the packed
// flag word, and the condition-code encoding used by the jump decoder.
package flag_unit_pkg;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_O = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_S = 3;

    typedef logic [3:0] flags_t;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_C      = 4'd3,
        COND_NC     = 4'd4,
        COND_S      = 4'd5,
        COND_NS     = 4'd6,
        COND_O      = 4'd7,
        COND_NO     = 4'd8,
        COND_UGT    = 4'd9,
        COND_ULE    = 4'd10,
        COND_SLT    = 4'd11,
        COND_SGE    = 4'd12,
        COND_SGT    = 4'd13,
        COND_SLE    = 4'd14,
        COND_NEVER  = 4'd15
    } cond_e;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Purely combinational condition evaluator: flag word + condition code in,
// branch-taken decision out. C set means unsigned borrow (a < b).
module flag_cond_eval
    import flag_unit_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_sel_i,
    output logic       cond_true_o
);

    logic z, o, c, s, lt;

    always_comb begin
        z  = flags_i[FLAG_Z];
        o  = flags_i[FLAG_O];
        c  = flags_i[FLAG_C];
        s  = flags_i[FLAG_S];
        lt = s ^ o;
        cond_true_o = 1'b0;
        unique case (cond_e'(cond_sel_i))
            COND_ALWAYS: cond_true_o = 1'b1;
            COND_Z:      cond_true_o = z;
            COND_NZ:     cond_true_o = ~z;
            COND_C:      cond_true_o = c;
            COND_NC:     cond_true_o = ~c;
            COND_S:      cond_true_o = s;
            COND_NS:     cond_true_o = ~s;
            COND_O:      cond_true_o = o;
            COND_NO:     cond_true_o = ~o;
            COND_UGT:    cond_true_o = ~c & ~z;
            COND_ULE:    cond_true_o = c | z;
            COND_SLT:    cond_true_o = lt;
            COND_SGE:    cond_true_o = ~lt;
            COND_SGT:    cond_true_o = ~lt & ~z;
            COND_SLE:    cond_true_o = lt | z;
            COND_NEVER:  cond_true_o = 1'b0;
            default:     cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// CPU status-flag register with per-flag write mask, multi-byte zero chaining,
// a save/restore flag stack and a condition evaluator on the registered flags.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned SPW        = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       flag_mask,
    input  logic             zchain,
    input  logic [WIDTH-1:0] result,
    input  logic             overflow,
    input  logic             carry,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [3:0]       cond_sel,
    output logic             cond_true,
    output logic             zflag,
    output logic             oflag,
    output logic             cflag,
    output logic             sflag,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err,
    output logic [SPW-1:0]   sp
);

    // Storage is rounded up to a power of two so sp can index it by truncation.
    localparam int unsigned IW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned ENTRIES = 1 << IW;

    flags_t           flags_q, flags_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    flags_t           stack_q [ENTRIES];

    logic             do_push, do_pop, both;
    logic             empty, full, new_err, stack_wr;
    logic [SPW-1:0]   sp_dec;
    logic [IW-1:0]    wr_idx, rd_idx;
    flags_t           alu_flags;

    assign empty  = (sp_q == '0);
    assign full   = (sp_q == SPW'(STACK_DEPTH));
    assign sp_dec = sp_q - 1'b1;
    assign wr_idx = sp_q[IW-1:0];
    assign rd_idx = sp_dec[IW-1:0];

    always_comb begin
        do_push = push & ~pop;
        do_pop  = pop & ~push;
        both    = push & pop;
        new_err = both | (do_push & full) | (do_pop & empty);

        alu_flags         = '0;
        alu_flags[FLAG_Z] = zchain ? (flags_q[FLAG_Z] & (result == '0)) : (result == '0);
        alu_flags[FLAG_O] = overflow;
        alu_flags[FLAG_C] = carry;
        alu_flags[FLAG_S] = result[WIDTH-1];

        flags_d  = flags_q;
        sp_d     = sp_q;
        stack_wr = 1'b0;

        // A pop request (even a failing one) suppresses the ALU update.
        if (do_pop) begin
            if (!empty) begin
                flags_d = stack_q[rd_idx];
                sp_d    = sp_dec;
            end
        end else if (we) begin
            flags_d = (alu_flags & flag_mask) | (flags_q & ~flag_mask);
        end

        if (do_push && !full) begin
            stack_wr = 1'b1;
            sp_d     = sp_q + 1'b1;
        end

        err_d = err_q;
        if (new_err)      err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (stack_wr && !rst) stack_q[wr_idx] <= flags_q;
    end

    flag_cond_eval u_cond (
        .flags_i     (flags_q),
        .cond_sel_i  (cond_sel),
        .cond_true_o (cond_true)
    );

    assign zflag       = flags_q[FLAG_Z];
    assign oflag       = flags_q[FLAG_O];
    assign cflag       = flags_q[FLAG_C];
    assign sflag       = flags_q[FLAG_S];
    assign stack_empty = empty;
    assign stack_full  = full;
    assign stack_err   = err_q;
    assign sp          = sp_q;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: stimulus queues hand-computed expected state
// after each clock edge; a negedge monitor pops and compares against the DUT.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] flag_mask;
    logic       zchain;
    logic [7:0] result;
    logic       overflow;
    logic       carry;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [3:0] cond_sel;
    logic       cond_true, zflag, oflag, cflag, sflag;
    logic       stack_empty, stack_full, stack_err;
    logic [2:0] sp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic [2:0] sp;
        logic       err;
        logic       cond;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    flag_unit #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .flag_mask   (flag_mask),
        .zchain      (zchain),
        .result      (result),
        .overflow    (overflow),
        .carry       (carry),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .cond_sel    (cond_sel),
        .cond_true   (cond_true),
        .zflag       (zflag),
        .oflag       (oflag),
        .cflag       (cflag),
        .sflag       (sflag),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err),
        .sp          (sp)
    );

    // Monitor: {cond, S, C, O, Z, sp, empty, full, err}
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [10:0] act, req;
            e   = sb.pop_front();
            act = {cond_true, sflag, cflag, oflag, zflag, sp, stack_empty, stack_full, stack_err};
            req = {e.cond, e.flags, e.sp, (e.sp == 3'd0), (e.sp == 3'd4), e.err};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s: got cond/SCOZ/sp/empty/full/err=%b required %b", e.name, act, req);
            end
        end
    end

    task automatic drv(input logic w, input logic [3:0] m, input logic zc, input logic [7:0] r,
                       input logic ov, input logic cy, input logic pu, input logic po,
                       input logic ce, input logic [3:0] cs);
        we = w; flag_mask = m; zchain = zc; result = r; overflow = ov; carry = cy;
        push = pu; pop = po; clr_err = ce; cond_sel = cs;
    endtask

    task automatic expect_state(input string n, input logic [3:0] f, input logic [2:0] s,
                                input logic er, input logic c);
        exp_t e;
        e.name = n; e.flags = f; e.sp = s; e.err = er; e.cond = c;
        sb.push_back(e);
    endtask

    // One clocked vector: edge, queue expectation, let the monitor sample at negedge.
    task automatic step(input string n, input logic [3:0] f, input logic [2:0] s,
                        input logic er, input logic c);
        @(posedge clk);
        #1;
        expect_state(n, f, s, er, c);
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0);
        expect_state("reset", 4'b0000, 3'd0, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Zero / sign detection
        drv(1, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd1); step("zero_res",   4'b0001, 0, 0, 1);
        drv(1, 4'hF, 0, 8'h80, 0, 0, 0, 0, 0, 4'd1); step("neg_res",    4'b1000, 0, 0, 0);
        drv(1, 4'hF, 0, 8'h40, 0, 0, 0, 0, 0, 4'd2); step("bit6_res",   4'b0000, 0, 0, 1);

        // Multi-byte zero chain
        drv(1, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd1); step("zc_lo0",     4'b0001, 0, 0, 1);
        drv(1, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 4'd1); step("zc_hi00",    4'b0001, 0, 0, 1);
        drv(1, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd1); step("zc_lo0b",    4'b0001, 0, 0, 1);
        drv(1, 4'hF, 1, 8'h01, 0, 0, 0, 0, 0, 4'd1); step("zc_hi01",    4'b0000, 0, 0, 0);
        drv(1, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 4'd1); step("zc_sticky0", 4'b0000, 0, 0, 0);

        // Per-flag mask
        drv(1, 4'b0001, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0); step("mask_z",    4'b0001, 0, 0, 1);
        drv(1, 4'b1110, 0, 8'h80, 1, 1, 0, 0, 0, 4'd0); step("mask_sco",  4'b1111, 0, 0, 1);
        drv(1, 4'b0100, 0, 8'h00, 0, 0, 0, 0, 0, 4'd3); step("mask_c",    4'b1011, 0, 0, 0);

        // Stack basics: push with concurrent we stacks pre-update flags
        drv(1, 4'hF, 0, 8'h00, 0, 1, 0, 0, 0, 4'd0); step("set_0101",   4'b0101, 0, 0, 1);
        drv(1, 4'hF, 0, 8'h80, 1, 0, 1, 0, 0, 4'd0); step("push_we",    4'b1010, 1, 0, 1);
        drv(1, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0); step("pop_wins",   4'b0101, 0, 0, 1);

        // Fill the stack with distinct entries
        drv(1, 4'hF, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0); step("push1",      4'b0001, 1, 0, 1);
        drv(1, 4'hF, 0, 8'h80, 0, 1, 1, 0, 0, 4'd0); step("push2",      4'b1100, 2, 0, 1);
        drv(1, 4'hF, 0, 8'h01, 1, 0, 1, 0, 0, 4'd0); step("push3",      4'b0010, 3, 0, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0); step("push4_full", 4'b0010, 4, 0, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0); step("push5_ovf",  4'b0010, 4, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 1, 4'd0); step("clr_err",    4'b0010, 4, 0, 1);

        // Unwind (LIFO order) and error cases
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0); step("pop4",       4'b0010, 3, 0, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0); step("pop3",       4'b1100, 2, 0, 1);
        drv(1, 4'hF, 0, 8'h00, 0, 0, 1, 1, 0, 4'd0); step("push_pop",   4'b0001, 2, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0); step("pop2",       4'b0001, 1, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0); step("pop1",       4'b0101, 0, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 1, 4'd0); step("clr_err2",   4'b0101, 0, 0, 1);
        drv(1, 4'hF, 0, 8'h80, 1, 0, 0, 1, 0, 4'd0); step("pop_empty",  4'b0101, 0, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 1, 1, 4'd0); step("err_wins",   4'b0101, 0, 1, 1);

        // Conditions after 3 - 5 = 0xFE: S=1 C=1 O=0 Z=0
        drv(1, 4'hF, 0, 8'hFE, 0, 1, 0, 0, 0, 4'd10); step("cond_ule",  4'b1100, 0, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd9);  step("cond_ugt",  4'b1100, 0, 1, 0);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd11); step("cond_slt",  4'b1100, 0, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd13); step("cond_sgt",  4'b1100, 0, 1, 0);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd12); step("cond_sge",  4'b1100, 0, 1, 0);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd14); step("cond_sle",  4'b1100, 0, 1, 1);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd15); step("cond_never",4'b1100, 0, 1, 0);
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd4);  step("cond_nc",   4'b1100, 0, 1, 0);

        // Reset asserted during a push aborts it
        drv(0, 4'hF, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0);
        rst = 1'b1;
        step("rst_mid_push", 4'b0000, 0, 0, 1);
        rst = 1'b0;
        drv(0, 4'hF, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0); step("after_rst", 4'b0000, 0, 0, 1);

        for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Parametrised successor to the CPU status-flag register; holds Z/O/C/S for an ALU of WIDTH bits.
- Adds per-flag write masking and multi-byte zero chaining.
- Adds a hardware flag save/restore stack (push on call/interrupt entry, pop on return).
- Adds a registered-flag condition evaluator feeding the jump unit.

Parameters:
- WIDTH, 8, ALU result width in bits (>=2).
- STACK_DEPTH, 4, number of saved flag sets (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- we  input  1  update flags from ALU this cycle
- flag_mask  input  4  per-flag write enable {S,C,O,Z}; bit 0 = Z, 1 = O, 2 = C, 3 = S
- zchain  input  1  Z accumulates across multi-byte op instead of overwriting
- result  input  WIDTH  ALU result
- overflow  input  1  ALU signed overflow
- carry  input  1  ALU carry/borrow out
- push  input  1  save current flags to stack
- pop  input  1  restore flags from stack
- clr_err  input  1  clear sticky stack_err
- cond_sel  input  4  condition code select
- cond_true  output  1  selected condition evaluated on registered flags
- zflag, oflag, cflag, sflag  output  1 each  registered flags
- stack_empty  output  1  sp == 0
- stack_full  output  1  sp == STACK_DEPTH
- stack_err  output  1  sticky overflow/underflow error
- sp  output  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (async, rst high):
  - all flags 0; sp = 0; stack_err = 0; stack storage contents don't-care.
  - Outputs: stack_empty = 1, stack_full = 0.
  - Reset mid-push/pop aborts the operation; the state after release is the reset state.
- Flag update, when we = 1 and no pop this cycle, at posedge clk, only for bits with flag_mask set:
  - Z <= (result == 0) across all WIDTH bits; with zchain = 1, Z <= Z & (result == 0).
  - O <= overflow; C <= carry; S <= result[WIDTH-1].
  - Unmasked flags hold their value.
- Push, with push = 1 and pop = 0:
  - If sp < STACK_DEPTH: stack[sp] <= current registered {S,C,O,Z}; sp <= sp + 1.
  - If full: no write, sp unchanged, stack_err <= 1.
  - A push may coincide with we. The stacked value is the pre-update flags, and the flags still update.
- Pop, with pop = 1 and push = 0:
  - If sp > 0: flags <= stack[sp-1]; sp <= sp - 1; a concurrent we is ignored (pop wins).
  - If empty: flags unchanged, we is still ignored, stack_err <= 1.
- push and pop both asserted: no stack operation, sp unchanged, flags follow we normally, stack_err <= 1.
- clr_err = 1: stack_err <= 0 unless a new error occurs the same cycle; the error wins.
- Latency:
  - Flags, sp and stack_err change one cycle after the request edge.
  - cond_true, stack_empty and stack_full are combinational from registers (zero latency from cond_sel).
- Carry convention: C = 1 means unsigned borrow, i.e. a < b for a - b.
- cond_sel encoding:
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O;
  - 9 UGT = !C & !Z; 10 ULE = C | Z;
  - 11 SLT = S ^ O; 12 SGE = !(S ^ O);
  - 13 SGT = !(S ^ O) & !Z; 14 SLE = (S ^ O) | Z;
  - 15 never.

Decomposition:
- Shared package holds:
  - flag bit index constants (FLAG_Z = 0, FLAG_O = 1, FLAG_C = 2, FLAG_S = 3);
  - the 4-bit flags typedef;
  - the cond_sel enum (COND_ALWAYS … COND_NEVER), which the decoder also uses.
- One natural sub-module: flag_cond_eval, a purely combinational flags + cond_sel → cond_true block, reused by the branch predictor.
- The stack stays inline: a register array plus sp.

Test Plan:
- Reset, then we = 1, mask = 4'hF, result = 8'h00, carry = 0, overflow = 0 → Z = 1, S = 0; cond_sel = 1 → cond_true = 1. Then result = 8'h80 → Z = 0, S = 1. Then result = 8'h40 → Z = 0; this checks that the full-width zero test covers bit 6 and below.
- Multi-byte zero chain: low byte result = 8'h00 with zchain = 0, then high byte 8'h00 with zchain = 1 → Z = 1. Repeat with a high byte of 8'h01 → Z = 0.
- Mask: flags = S1 C1 O1 Z1, then we with mask = 4'b0100, carry = 0 → only C clears, the others stay 1.
- Stack: push flags 4'b0101, overwrite with we, pop → flags return to 4'b0101 and sp goes 0→1→0. Push four times → stack_full = 1. A fifth push → stack_err = 1, sp = 4. clr_err → stack_err = 0.
- Pop on empty with we = 1 → flags unchanged, stack_err = 1. Simultaneous push + pop with sp = 2 → sp stays 2, stack_err = 1.
- Conditions: a - b with a = 3, b = 5 (C = 1, S = 1, O = 0) → ULE = 1, UGT = 0, SLT = 1, SGT = 0. Assert rst mid-push → sp = 0, all flags 0.
